// File: rtl/seq_mem_datapath_if.sv
// Strobe and data bundle between the sequential-memory controller and its datapath.
// The master side issues strobes and write data; the slave side returns addresses, reads and flags.
interface seq_mem_datapath_if #(
    parameter int DATA_W  = 8,
    parameter int DEPTH_A = 8,
    parameter int DEPTH_B = 4
);
    localparam int AW = $clog2(DEPTH_A);
    localparam int BW = $clog2(DEPTH_B);

    logic              wea;
    logic              inc_a;
    logic              web;
    logic              inc_b;
    logic [DATA_W-1:0] data_in_a;
    logic [AW-1:0]     addr_a;
    logic [BW-1:0]     addr_b;
    logic [DATA_W-1:0] dout1;
    logic [DATA_W-1:0] dout2;
    logic [DATA_W:0]   result_b;
    logic [DATA_W:0]   dout_b;
    logic              b_full;

    modport master (
        output wea, inc_a, web, inc_b, data_in_a,
        input  addr_a, addr_b, dout1, dout2, result_b, dout_b, b_full
    );

    modport slave (
        input  wea, inc_a, web, inc_b, data_in_a,
        output addr_a, addr_b, dout1, dout2, result_b, dout_b, b_full
    );
endinterface

// File: rtl/seq_mem_datapath.sv
// Memory A streamed through a one-word delay and compare/add-subtract unit,
// with pairwise results stored in Memory B behind a registered read port.
module seq_mem_datapath #(
    parameter int DATA_W  = 8,
    parameter int DEPTH_A = 8,
    parameter int DEPTH_B = 4
) (
    input logic               clk,
    input logic               rst,
    seq_mem_datapath_if.slave bus
);
    localparam int AW = $clog2(DEPTH_A);
    localparam int BW = $clog2(DEPTH_B);
    localparam int CW = $clog2(DEPTH_B) + 1;

    logic [DATA_W-1:0] mem_a [DEPTH_A];
    logic [DATA_W:0]   mem_b [DEPTH_B];
    logic [AW-1:0]     addr_a;
    logic [BW-1:0]     addr_b;
    logic [DATA_W-1:0] dout1;
    logic [DATA_W-1:0] dout2;
    logic [DATA_W:0]   result_b;
    logic [DATA_W:0]   dout_b;
    logic [CW-1:0]     b_cnt;
    logic              b_full;

    assign dout1  = mem_a[addr_a];
    assign b_full = (b_cnt == CW'(DEPTH_B));

    // Subtract only when strictly greater; ties and smaller take the full-width add.
    always_comb begin
        result_b = '0;
        if (dout2 > dout1)
            result_b = {1'b0, dout2 - dout1};
        else
            result_b = {1'b0, dout2} + {1'b0, dout1};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_a <= '0;
            dout2  <= '0;
            for (int i = 0; i < DEPTH_A; i++)
                mem_a[i] <= '0;
        end else begin
            if (bus.wea)
                mem_a[addr_a] <= bus.data_in_a;
            if (bus.inc_a)
                addr_a <= addr_a + AW'(1);
            dout2 <= dout1;
        end
    end

    // dout_b samples the pre-write word, so a same-edge write shows up one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_b <= '0;
            dout_b <= '0;
            b_cnt  <= '0;
            for (int i = 0; i < DEPTH_B; i++)
                mem_b[i] <= '0;
        end else begin
            if (bus.web)
                mem_b[addr_b] <= result_b;
            if (bus.inc_b)
                addr_b <= addr_b + BW'(1);
            dout_b <= mem_b[addr_b];
            if (bus.web && !b_full)
                b_cnt <= b_cnt + CW'(1);
        end
    end

    assign bus.addr_a   = addr_a;
    assign bus.addr_b   = addr_b;
    assign bus.dout1    = dout1;
    assign bus.dout2    = dout2;
    assign bus.result_b = result_b;
    assign bus.dout_b   = dout_b;
    assign bus.b_full   = b_full;
endmodule

// File: tb/tb_seq_mem_datapath.sv
// Scoreboard bench: stimulus pushes post-edge expectations from a reference model,
// an independent monitor pops and compares one entry after every rising edge.
module tb_seq_mem_datapath;
    localparam int DATA_W  = 8;
    localparam int DEPTH_A = 8;
    localparam int DEPTH_B = 4;

    typedef struct {
        int aa;
        int ab;
        int d1;
        int d2;
        int rb;
        int db;
        int bf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;

    // reference state
    int ma[DEPTH_A];
    int mb[DEPTH_B];
    int m_aa, m_ab, m_d2, m_db, m_writes;

    seq_mem_datapath_if #(.DATA_W(DATA_W), .DEPTH_A(DEPTH_A), .DEPTH_B(DEPTH_B)) bus ();

    seq_mem_datapath #(.DATA_W(DATA_W), .DEPTH_A(DEPTH_A), .DEPTH_B(DEPTH_B)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic int alu(int a, int b);
        if (a > b) return a - b;
        return a + b;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH_A; i++) ma[i] = 0;
        for (int i = 0; i < DEPTH_B; i++) mb[i] = 0;
        m_aa = 0; m_ab = 0; m_d2 = 0; m_db = 0; m_writes = 0;
    endtask

    function automatic exp_t model_view();
        exp_t e;
        e.aa = m_aa;
        e.ab = m_ab;
        e.d1 = ma[m_aa];
        e.d2 = m_d2;
        e.rb = alu(m_d2, ma[m_aa]);
        e.db = m_db;
        e.bf = (m_writes >= DEPTH_B) ? 1 : 0;
        return e;
    endfunction

    // One clock of the datapath in terms of whole-word values.
    task automatic model_step(int wea, int inca, int web, int incb, int din);
        int d1, r, old_b;
        d1    = ma[m_aa];
        r     = alu(m_d2, d1);
        old_b = mb[m_ab];
        if (web)  mb[m_ab] = r;
        if (wea)  ma[m_aa] = din;
        if (inca) m_aa = (m_aa + 1) % DEPTH_A;
        if (incb) m_ab = (m_ab + 1) % DEPTH_B;
        if (web)  m_writes++;
        m_d2 = d1;
        m_db = old_b;
    endtask

    task automatic cycle(int wea, int inca, int web, int incb, int din);
        @(negedge clk);
        bus.wea       = wea[0];
        bus.inc_a     = inca[0];
        bus.web       = web[0];
        bus.inc_b     = incb[0];
        bus.data_in_a = din[7:0];
        model_step(wea, inca, web, incb, din);
        sb.push_back(model_view());
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        bus.wea = 0; bus.inc_a = 0; bus.web = 0; bus.inc_b = 0; bus.data_in_a = '0;
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_addr_a", int'(bus.addr_a), 0);
        check("rst_addr_b", int'(bus.addr_b), 0);
        check("rst_dout2",  int'(bus.dout2), 0);
        check("rst_dout_b", int'(bus.dout_b), 0);
        check("rst_b_full", int'(bus.b_full), 0);
        check("rst_dout1",  int'(bus.dout1), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("addr_a",   int'(bus.addr_a),   mon_e.aa);
                check("addr_b",   int'(bus.addr_b),   mon_e.ab);
                check("dout1",    int'(bus.dout1),    mon_e.d1);
                check("dout2",    int'(bus.dout2),    mon_e.d2);
                check("result_b", int'(bus.result_b), mon_e.rb);
                check("dout_b",   int'(bus.dout_b),   mon_e.db);
                check("b_full",   int'(bus.b_full),   mon_e.bf);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int load_vals[8];
        load_vals = '{5, 3, 2, 9, 7, 7, 255, 1};
        bus.wea = 0; bus.inc_a = 0; bus.web = 0; bus.inc_b = 0; bus.data_in_a = '0;
        #3;
        do_reset();

        foreach (load_vals[i]) cycle(1, 1, 0, 0, load_vals[i]);
        check("load_wrap_addr_a", int'(bus.addr_a), 0);
        check("load_dout1", int'(bus.dout1), 5);

        cycle(0, 1, 0, 0, 0);
        check("sub_5_3", int'(bus.result_b), 2);
        cycle(0, 0, 1, 1, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        check("add_2_9", int'(bus.result_b), 11);
        cycle(0, 0, 1, 1, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        check("equal_7_7", int'(bus.result_b), 14);
        cycle(0, 0, 1, 1, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        check("pre_full", int'(bus.b_full), 0);
        cycle(1, 0, 0, 0, 255);
        check("add_carry_1_255", int'(bus.result_b), 256);
        cycle(0, 0, 1, 1, 0);
        check("full_after_4", int'(bus.b_full), 1);
        check("addr_b_wrap", int'(bus.addr_b), 0);
        cycle(0, 0, 1, 0, 0);
        check("full_sticky", int'(bus.b_full), 1);

        // same-edge write and increment, then walk back to the written slot
        cycle(0, 0, 1, 1, 0);
        for (int i = 0; i < DEPTH_B - 1; i++) cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++)
            cycle(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3) == 0), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 255)));

        do_reset();
        for (int i = 0; i < 300; i++)
            cycle(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 255)));

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
